// File: rtl/pc_next_unit.sv
// Program counter register and next-PC selection.
// Picks between the sequential, branch, jump and jump-register targets, and
// holds a conditional branch in WAIT_COND until the ALU resolves its condition.
// branch_offset arrives from ShiftLeft2, so it is already shifted left by two.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_en,
    input  logic        ctl_valid,
    input  logic [1:0]  ctl_type,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_addr,
    input  logic        cond_valid,
    input  logic        cond_taken,
    input  logic        err_clr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        redirect,
    output logic        misalign_err
);

    typedef enum logic {
        IDLE,
        WAIT_COND
    } state_t;

    localparam logic [1:0] TYPE_SEQ    = 2'b00;
    localparam logic [1:0] TYPE_BRANCH = 2'b01;
    localparam logic [1:0] TYPE_JUMP   = 2'b10;

    state_t      state;
    logic [31:0] tgtReg;
    logic [31:0] fallReg;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] directTarget;
    logic        directMisaligned;
    logic        tgtMisaligned;
    logic        misalignEvent;

    // Work out the candidate targets and flag any that break word alignment.
    always_comb begin
        pc_plus4         = pc + 32'd4;
        branchTarget     = pc_plus4 + branch_offset;
        jumpTarget       = {pc_plus4[31:28], jump_index, 2'b00};
        directTarget     = (ctl_type == TYPE_JUMP) ? jumpTarget : jr_addr;
        directMisaligned = |directTarget[1:0];
        tgtMisaligned    = |tgtReg[1:0];
        misalignEvent    = 1'b0;
        if (state == IDLE) begin
            misalignEvent = pc_en && ctl_valid && ctl_type[1] && directMisaligned;
        end else begin
            misalignEvent = cond_valid && cond_taken && tgtMisaligned;
        end
    end

    assign busy = (state == WAIT_COND);

    // Update the PC, the pending-branch state, the redirect pulse and the sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            tgtReg       <= 32'd0;
            fallReg      <= 32'd0;
            redirect     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_en) begin
                        if (!ctl_valid || ctl_type == TYPE_SEQ) begin
                            pc <= pc_plus4;
                        end else if (ctl_type == TYPE_BRANCH) begin
                            tgtReg  <= branchTarget;
                            fallReg <= pc_plus4;
                            state   <= WAIT_COND;
                        end else if (directMisaligned) begin
                            pc <= pc_plus4;
                        end else begin
                            pc       <= directTarget;
                            redirect <= 1'b1;
                        end
                    end
                end
                WAIT_COND: begin
                    if (cond_valid) begin
                        state <= IDLE;
                        if (cond_taken && !tgtMisaligned) begin
                            pc       <= tgtReg;
                            redirect <= 1'b1;
                        end else begin
                            pc <= fallReg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (misalignEvent) begin
                misalign_err <= 1'b1;
            end else if (err_clr) begin
                misalign_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a directed sequence followed by random traffic,
// all compared against a cycle-level reference model of the PC rules.
module tb_pc_next_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        pc_en;
    logic        ctl_valid;
    logic [1:0]  ctl_type;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_addr;
    logic        cond_valid;
    logic        cond_taken;
    logic        err_clr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        redirect;
    logic        misalign_err;

    int checks;
    int failures;

    logic [31:0] mPc;
    logic        mPending;
    logic [31:0] mTarget;
    logic [31:0] mFall;
    logic        mErr;
    logic        mRedirect;

    pc_next_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_en        (pc_en),
        .ctl_valid    (ctl_valid),
        .ctl_type     (ctl_type),
        .branch_offset(branch_offset),
        .jump_index   (jump_index),
        .jr_addr      (jr_addr),
        .cond_valid   (cond_valid),
        .cond_taken   (cond_taken),
        .err_clr      (err_clr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .busy         (busy),
        .redirect     (redirect),
        .misalign_err (misalign_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        mPc       = RESET_PC;
        mPending  = 1'b0;
        mTarget   = 32'd0;
        mFall     = 32'd0;
        mErr      = 1'b0;
        mRedirect = 1'b0;
    endtask

    task automatic checkAgainstModel();
        checkOutput("pc", pc, mPc);
        checkOutput("pc_plus4", pc_plus4, mPc + 32'd4);
        checkOutput("busy", {31'd0, busy}, {31'd0, mPending});
        checkOutput("redirect", {31'd0, redirect}, {31'd0, mRedirect});
        checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, mErr});
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input logic en, input logic valid, input logic [1:0] kind,
                                 input logic [31:0] offset, input logic [25:0] index,
                                 input logic [31:0] jr, input logic cv, input logic ct,
                                 input logic clr);
        logic [31:0] nextPc;
        logic [31:0] seqPc;
        logic [31:0] dest;
        logic        nextPending;
        logic [31:0] nextTarget;
        logic [31:0] nextFall;
        logic        nextRedirect;
        logic        badAlign;
        pc_en         = en;
        ctl_valid     = valid;
        ctl_type      = kind;
        branch_offset = offset;
        jump_index    = index;
        jr_addr       = jr;
        cond_valid    = cv;
        cond_taken    = ct;
        err_clr       = clr;
        seqPc        = mPc + 32'd4;
        nextPc       = mPc;
        nextPending  = mPending;
        nextTarget   = mTarget;
        nextFall     = mFall;
        nextRedirect = 1'b0;
        badAlign     = 1'b0;
        if (!mPending) begin
            if (en) begin
                if (!valid || kind == 2'b00) begin
                    nextPc = seqPc;
                end else if (kind == 2'b01) begin
                    nextTarget  = seqPc + offset;
                    nextFall    = seqPc;
                    nextPending = 1'b1;
                end else begin
                    dest = (kind == 2'b10) ? ((seqPc & 32'hF000_0000) | ({6'd0, index} * 32'd4)) : jr;
                    if (dest % 4 != 0) begin
                        badAlign = 1'b1;
                        nextPc   = seqPc;
                    end else begin
                        nextPc       = dest;
                        nextRedirect = 1'b1;
                    end
                end
            end
        end else if (cv) begin
            nextPending = 1'b0;
            if (ct && mTarget % 4 != 0) begin
                badAlign = 1'b1;
                nextPc   = mFall;
            end else if (ct) begin
                nextPc       = mTarget;
                nextRedirect = 1'b1;
            end else begin
                nextPc = mFall;
            end
        end
        @(posedge clk);
        #1;
        mPc       = nextPc;
        mPending  = nextPending;
        mTarget   = nextTarget;
        mFall     = nextFall;
        mRedirect = nextRedirect;
        mErr      = badAlign ? 1'b1 : (clr ? 1'b0 : mErr);
        checkAgainstModel();
    endtask

    task automatic idleStep(input logic en);
        applyStimulus(en, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jrStep(input logic [31:0] dest);
        applyStimulus(1'b1, 1'b1, 2'b11, 32'd0, 26'd0, dest, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic branchStep(input logic [31:0] offset);
        applyStimulus(1'b1, 1'b1, 2'b01, offset, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolveStep(input logic taken);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b1, taken, 1'b0);
    endtask

    // Directed scenarios first, then randomized traffic against the model.
    initial begin
        logic [15:0] imm;
        logic [31:0] offset;
        logic [31:0] jr;
        checks   = 0;
        failures = 0;
        reset_n       = 1'b0;
        pc_en         = 1'b0;
        ctl_valid     = 1'b0;
        ctl_type      = 2'b00;
        branch_offset = 32'd0;
        jump_index    = 26'd0;
        jr_addr       = 32'd0;
        cond_valid    = 1'b0;
        cond_taken    = 1'b0;
        err_clr       = 1'b0;
        resetModel();
        #1;
        checkAgainstModel();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Sequential stepping out of reset.
        checkOutput("seq_pc0", pc, 32'h0);
        idleStep(1'b1);
        checkOutput("seq_pc1", pc, 32'h4);
        idleStep(1'b1);
        checkOutput("seq_pc2", pc, 32'h8);
        idleStep(1'b1);
        checkOutput("seq_pc3", pc, 32'hC);
        idleStep(1'b1);
        checkOutput("seq_pc4", pc, 32'h10);

        // Forward branch taken two cycles after entry.
        branchStep(32'h28);
        checkOutput("br_busy", {31'd0, busy}, 32'd1);
        checkOutput("br_hold", pc, 32'h10);
        idleStep(1'b1);
        checkOutput("br_hold2", pc, 32'h10);
        resolveStep(1'b1);
        checkOutput("br_taken_pc", pc, 32'h3C);
        checkOutput("br_taken_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("br_taken_busy", {31'd0, busy}, 32'd0);
        idleStep(1'b1);
        checkOutput("br_redirect_pulse", {31'd0, redirect}, 32'd0);
        checkOutput("br_after_pc", pc, 32'h40);

        // Backward branch, taken then not taken.
        branchStep(32'hFFFF_FFF0);
        resolveStep(1'b1);
        checkOutput("back_taken_pc", pc, 32'h34);
        jrStep(32'h40);
        branchStep(32'hFFFF_FFF0);
        resolveStep(1'b0);
        checkOutput("back_nt_pc", pc, 32'h44);
        checkOutput("back_nt_redirect", {31'd0, redirect}, 32'd0);

        // Jump keeps the upper nibble; sequential wraps at the top of memory.
        jrStep(32'hA000_0008);
        applyStimulus(1'b1, 1'b1, 2'b10, 32'd0, 26'h10, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("jump_pc", pc, 32'hA000_0040);
        checkOutput("jump_redirect", {31'd0, redirect}, 32'd1);
        jrStep(32'hFFFF_FFFC);
        idleStep(1'b1);
        checkOutput("wrap_pc", pc, 32'h0);

        // Misaligned jump-register and the sticky error flag.
        jrStep(32'h102);
        checkOutput("mis_err", {31'd0, misalign_err}, 32'd1);
        checkOutput("mis_pc", pc, 32'h4);
        checkOutput("mis_redirect", {31'd0, redirect}, 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("mis_clr", {31'd0, misalign_err}, 32'd0);
        applyStimulus(1'b1, 1'b1, 2'b11, 32'd0, 26'd0, 32'h102, 1'b0, 1'b0, 1'b1);
        checkOutput("mis_set_wins", {31'd0, misalign_err}, 32'd1);

        // Stall, then reset in the middle of a pending branch.
        repeat (3) idleStep(1'b0);
        checkOutput("stall_pc", pc, 32'hC);
        branchStep(32'h100);
        checkOutput("pend_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midreset_pc", pc, RESET_PC);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkAgainstModel();
        #1;
        reset_n = 1'b1;
        resolveStep(1'b1);
        checkOutput("post_reset_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("post_reset_pc", pc, RESET_PC + 32'd4);
        idleStep(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            imm    = 16'($urandom);
            offset = {{14{imm[15]}}, imm, 2'b00};
            if ($urandom_range(0, 15) == 0) offset = offset | 32'($urandom_range(1, 3));
            jr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) jr = jr | 32'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                          2'($urandom), offset, 26'($urandom), jr,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
